// File: rtl/aes_tround_pipe.sv
// AES encryption round (full: SubBytes/ShiftRows/MixColumns/AddRoundKey, or final: no MixColumns) on LANES 128-bit states per beat.
// Latency: PIPE cycles from accept to out_valid (PIPE=1 output reg only, PIPE=2 lookup reg + output reg); 1 beat/cycle throughput.
// Backpressure: valid/ready; each stage advances when downstream is empty or draining; in_ready is combinational from out_ready.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        input handshake; in_final selects the final-round form for that beat
//   in_state/in_key          LANES x 128-bit state and round key, lane L at [128L+127:128L]
//   in_tag                   sideband returned unchanged with the result
//   out_valid/out_ready      output handshake; out_state/out_tag held stable while stalled
module aes_tround_pipe #(
    parameter int LANES = 1,
    parameter int PIPE  = 2,
    parameter int TAG_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_final,
    input  logic [128*LANES-1:0] in_state,
    input  logic [128*LANES-1:0] in_key,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [128*LANES-1:0] out_state,
    output logic [TAG_W-1:0]     out_tag
);
    localparam int W = 128 * LANES;

    // GF(2^8) multiply by x, reduction polynomial 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // S-box computed as x^254 (multiplicative inverse, 0 maps to 0) followed
    // by the AES affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
        x2   = gf_mul(x, x);
        x4   = gf_mul(x2, x2);
        x8   = gf_mul(x4, x4);
        x16  = gf_mul(x8, x8);
        x32  = gf_mul(x16, x16);
        x64  = gf_mul(x32, x32);
        x128 = gf_mul(x64, x64);
        inv  = gf_mul(gf_mul(gf_mul(x128, x64), gf_mul(x32, x16)),
                      gf_mul(gf_mul(x8, x4), x2));
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // T0 entry from an S-box output: row0 = 2S, row1 = S, row2 = S, row3 = 3S.
    function automatic logic [31:0] t0(input logic [7:0] s);
        return {xtime(s) ^ s, s, s, xtime(s)};
    endfunction

    function automatic logic [31:0] rotl8(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Lookup stage: ShiftRows folded into the S-box input selection, so
    // w_sub already holds S(shifted byte) in output byte positions.
    logic [W-1:0] w_sub;
    for (genvar l = 0; l < LANES; l++) begin : g_sub_lane
        for (genvar j = 0; j < 4; j++) begin : g_col
            for (genvar r = 0; r < 4; r++) begin : g_row
                assign w_sub[128*l + 8*(4*j+r) +: 8] =
                    sbox(in_state[128*l + 8*(4*((j+r)%4)+r) +: 8]);
            end
        end
    end

    // Inputs to the combine stage, sourced either from the lookup register
    // (PIPE=2) or directly from the lookup logic (PIPE=1).
    logic             w_b_vld;
    logic             w_b_fin;
    logic [W-1:0]     w_b_sub;
    logic [W-1:0]     w_b_key;
    logic [TAG_W-1:0] w_b_tag;
    logic             w_o_load;

    logic             r_o_vld;
    logic [W-1:0]     r_o_state;
    logic [TAG_W-1:0] r_o_tag;

    // Output register may take a new beat when empty or being drained.
    assign w_o_load = ~r_o_vld | out_ready;

    if (PIPE == 2) begin : g_pipe2
        logic             r_s1_vld;
        logic             r_s1_fin;
        logic [W-1:0]     r_s1_sub;
        logic [W-1:0]     r_s1_key;
        logic [TAG_W-1:0] r_s1_tag;

        // Stage 1 is free when empty or when its beat moves to the output reg.
        assign in_ready = ~rst & (~r_s1_vld | w_o_load);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_s1_vld <= 1'b0;
            end else if (in_ready) begin
                r_s1_vld <= in_valid;
            end
        end

        always_ff @(posedge clk) begin
            if (in_valid && in_ready) begin
                r_s1_fin <= in_final;
                r_s1_sub <= w_sub;
                r_s1_key <= in_key;
                r_s1_tag <= in_tag;
            end
        end

        assign w_b_vld = r_s1_vld;
        assign w_b_fin = r_s1_fin;
        assign w_b_sub = r_s1_sub;
        assign w_b_key = r_s1_key;
        assign w_b_tag = r_s1_tag;
    end else begin : g_pipe1
        assign in_ready = ~rst & w_o_load;
        assign w_b_vld  = in_valid & in_ready;
        assign w_b_fin  = in_final;
        assign w_b_sub  = w_sub;
        assign w_b_key  = in_key;
        assign w_b_tag  = in_tag;
    end

    // Combine stage: T-table XOR per column (T1..T3 as rotations of T0),
    // or plain substituted bytes for the final round, then AddRoundKey.
    logic [W-1:0] w_res;
    for (genvar l = 0; l < LANES; l++) begin : g_mix_lane
        for (genvar j = 0; j < 4; j++) begin : g_col
            logic [31:0] w_col;
            logic [31:0] w_mix;
            assign w_col = w_b_sub[128*l + 32*j +: 32];
            assign w_mix = t0(w_col[7:0])
                         ^ rotl8(t0(w_col[15:8]))
                         ^ rotl8(rotl8(t0(w_col[23:16])))
                         ^ rotl8(rotl8(rotl8(t0(w_col[31:24]))));
            assign w_res[128*l + 32*j +: 32] =
                w_b_key[128*l + 32*j +: 32] ^ (w_b_fin ? w_col : w_mix);
        end
    end

    // Output register: data only updates when a real beat arrives, so the
    // presented result stays stable through a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_o_vld   <= 1'b0;
            r_o_state <= '0;
            r_o_tag   <= '0;
        end else if (w_o_load) begin
            r_o_vld <= w_b_vld;
            if (w_b_vld) begin
                r_o_state <= w_res;
                r_o_tag   <= w_b_tag;
            end
        end
    end

    assign out_valid = r_o_vld;
    assign out_state = r_o_state;
    assign out_tag   = r_o_tag;
endmodule

// File: tb/tb_aes_tround_pipe.sv
// Self-checking bench for aes_tround_pipe (LANES=4, PIPE=2) using directed AES round vectors.
// Latency: expected results are queued on accept and compared by a monitor when the DUT emits.
// Backpressure: exercised with random, held-low and released out_ready, plus reset mid-stream.
module tb_aes_tround_pipe;
    localparam int LANES = 4;
    localparam int PIPE  = 2;
    localparam int TAG_W = 8;
    localparam int W     = 128 * LANES;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_final;
    logic [W-1:0]     in_state;
    logic [W-1:0]     in_key;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_state;
    logic [TAG_W-1:0] out_tag;

    always #5 clk = ~clk;

    aes_tround_pipe #(.LANES(LANES), .PIPE(PIPE), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_final  (in_final),
        .in_state  (in_state),
        .in_key    (in_key),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_tag   (out_tag)
    );

    typedef struct packed {
        logic [W-1:0]     st;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    bit   stream_done = 1'b0;

    task automatic check(input string name, input logic [639:0] act, input logic [639:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // FIPS-197 listings give byte 0 first; the DUT packs byte 0 at the LSB.
    function automatic logic [127:0] bswap(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = v[8*(15-i) +: 8];
        return r;
    endfunction

    // Hand-derived vectors. sel: 0 = state, 1 = key, 2 = expected result.
    function automatic logic [127:0] vec(input logic fin, input int idx, input int sel);
        logic [127:0] st, k, x;
        logic [1:0]   i2;
        i2 = idx[1:0];
        st = '0; k = '0; x = '0;
        case ({fin, i2})
            3'b000: x = {16{8'h63}};
            3'b001: begin st = 128'h1; x = {{12{8'h63}}, 32'h427c7c5d}; end
            3'b010: begin k = {16{8'hff}}; x = {16{8'h9c}}; end
            3'b011: begin
                st = bswap(128'h193de3bea0f4e22b9ac68d2ae9f84808);
                k  = bswap(128'ha0fafe1788542cb123a339392a6c7605);
                x  = bswap(128'ha49c7ff2689f352b6b5bea43026a5049);
            end
            3'b100: x = {16{8'h63}};
            3'b101: begin st = 128'h1; x = {{15{8'h63}}, 8'h7c}; end
            3'b110: begin
                st = bswap(128'heb40f21e592e38848ba113e71bc342d2);
                k  = bswap(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
                x  = bswap(128'h3925841d02dc09fbdc118597196a0b32);
            end
            default: begin k = {16{8'hff}}; x = {16{8'h9c}}; end
        endcase
        case (sel)
            0:       return st;
            1:       return k;
            default: return x;
        endcase
    endfunction

    // Beat b: every third beat is a final round; lane L uses vector (b+L)%4.
    task automatic make_beat(input int b, output logic fin, output logic [W-1:0] st,
                             output logic [W-1:0] k, output logic [W-1:0] x);
        fin = (b % 3 == 2);
        for (int l = 0; l < LANES; l++) begin
            st[128*l +: 128] = vec(fin, (b + l) % 4, 0);
            k[128*l +: 128]  = vec(fin, (b + l) % 4, 1);
            x[128*l +: 128]  = vec(fin, (b + l) % 4, 2);
        end
    endtask

    task automatic present(input int b);
        logic fin;
        logic [W-1:0] st, k, x;
        make_beat(b, fin, st, k, x);
        in_valid = 1'b1;
        in_final = fin;
        in_state = st;
        in_key   = k;
        in_tag   = TAG_W'(b);
    endtask

    task automatic send(input int b);
        logic fin;
        logic [W-1:0] st, k, x;
        logic acc;
        int n;
        exp_t e;
        make_beat(b, fin, st, k, x);
        present(b);
        n = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                e.st  = x;
                e.tag = TAG_W'(b);
                sb_q.push_back(e);
                break;
            end
            n++;
            if (n > 500) begin
                checks++;
                failures++;
                $display("FAIL send_timeout beat=%0d in_ready stayed 0, required 1", b);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_pending", sb_q.size(), 0);
    endtask

    // Scoreboard monitor: compare every emitted beat against the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat tag=%0d, required no output", out_tag);
            end else begin
                mon_e = sb_q.pop_front();
                check("result", {out_state, out_tag}, mon_e);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_final = 1'b0; in_state = '0; in_key = '0;
        in_tag = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_state", out_state, 0);
        check("rst_out_tag", out_tag, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1);

        // Latency of an unstalled beat.
        @(posedge clk); #1 out_ready = 1'b1;
        send(0);
        @(negedge clk);
        check("lat_early_valid", out_valid, 0);
        @(negedge clk);
        check("lat_valid", out_valid, 1);
        @(posedge clk); #1;

        // Back-to-back directed beats, full and final rounds mixed.
        for (int b = 1; b < 12; b++) send(b);
        drain();

        // 64 beats with random output backpressure.
        fork
            begin
                for (int b = 12; b < 76; b++) send(b);
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Hold out_ready low: two beats fill the pipe, then in_ready drops.
        @(posedge clk); #1 out_ready = 1'b0;
        send(76);
        send(77);
        present(78);
        @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        for (int c = 0; c < 5; c++) begin
            check("stall_hold", {out_valid, out_state, out_tag}, {1'b1, sb_q[0].st, sb_q[0].tag});
            @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        send(78);
        send(79);
        drain();

        // Reset with two beats in flight: both must vanish.
        @(posedge clk); #1 out_ready = 1'b0;
        send(80);
        send(81);
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("midrst_in_ready", in_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_state", out_state, 0);
        check("midrst_in_ready_after", in_ready, 1);
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        send(82);
        send(83);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
